// File: rtl/binary_mul_13_arb.sv
// Round-robin front end sharing one pipelined signed 13x13 multiplier among NREQ requesters,
// with per-requester credits and an IDLE/RUN/DRAIN flow. Define BINARY_MUL_ARB_STATS_EN for grant_cnt/busy_cnt.
module binary_mul_13_arb #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 14,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [13*NREQ-1:0]   req_a,
    input  logic [13*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      resp_valid,
    output logic [24:0]          resp_p,
    output logic [12:0]          mul_a,
    output logic [12:0]          mul_b,
    output logic                 mul_en,
    input  logic [24:0]          mul_p,
    output logic                 drained
`ifdef BINARY_MUL_ARB_STATS_EN
    ,
    output logic [16*NREQ-1:0]   grant_cnt,
    output logic [31:0]          busy_cnt
`endif
);

    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    // mul_p carries the product LATENCY+1 en-high edges after mul_a/mul_b load
    // (multiplier input capture plus LATENCY stages), so the tag line is one longer.
    localparam int DEPTH = LATENCY + 2;
    localparam int LAST  = DEPTH - 1;
    localparam logic [3:0] CRED_MAX = 4'(MAX_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [3:0]        cnt_q [NREQ];
    logic [3:0]        cnt_d [NREQ];
    logic              tag_v_q [DEPTH];
    logic              tag_v_d [DEPTH];
    logic [IDW-1:0]    tag_id_q [DEPTH];
    logic [IDW-1:0]    tag_id_d [DEPTH];
    logic [12:0]       mul_a_q, mul_a_d;
    logic [12:0]       mul_b_q, mul_b_d;
    logic [24:0]       resp_p_q, resp_p_d;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
    logic              drained_q, drained_d;

    logic [12:0]       op_a [NREQ];
    logic [12:0]       op_b [NREQ];
    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   inc;
    logic [NREQ-1:0]   dec;
    logic [NREQ-1:0]   resp_hit;
    logic [NREQ-1:0]   cnt_nz;
    logic [DEPTH-1:0]  tag_v_vec;
    logic              run_open;
    logic              grant_any;
    logic [IDW-1:0]    grant_id;
    logic [IDW:0]      rr_idx;
    logic              pipe_busy;
    logic              pipe_empty;

    assign run_open = (state_q == RUN) && en && !flush;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign op_a[gi]     = req_a[13*gi +: 13];
        assign op_b[gi]     = req_b[13*gi +: 13];
        assign eligible[gi] = req_valid[gi] && (cnt_q[gi] != CRED_MAX) && run_open;
        assign req_ready[gi] = grant_any && (grant_id == IDW'(gi));
        assign inc[gi]      = grant_any && (grant_id == IDW'(gi));
        assign resp_hit[gi] = tag_v_q[LAST] && (tag_id_q[LAST] == IDW'(gi));
        assign dec[gi]      = en && resp_hit[gi];
        // A simultaneous accept and response leave the credit count unchanged.
        assign cnt_d[gi]    = (inc[gi] && !dec[gi]) ? cnt_q[gi] + 4'd1 :
                              (dec[gi] && !inc[gi]) ? cnt_q[gi] - 4'd1 : cnt_q[gi];
        assign cnt_nz[gi]   = (cnt_q[gi] != 4'd0);
        assign resp_valid_d[gi] = en ? resp_hit[gi] : resp_valid_q[gi];
    end

    // Search starts at the pointer and wraps; first eligible requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        rr_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (rr_idx >= (IDW+1)'(NREQ)) begin
                rr_idx = rr_idx - (IDW+1)'(NREQ);
            end
            if (!grant_any && eligible[rr_idx[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = rr_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    assign mul_a_d = grant_any ? op_a[grant_id] : mul_a_q;
    assign mul_b_d = grant_any ? op_b[grant_id] : mul_b_q;

    assign tag_v_d[0]  = en ? grant_any : tag_v_q[0];
    assign tag_id_d[0] = en ? grant_id  : tag_id_q[0];

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_tag
        assign tag_v_d[gi]  = en ? tag_v_q[gi-1]  : tag_v_q[gi];
        assign tag_id_d[gi] = en ? tag_id_q[gi-1] : tag_id_q[gi];
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tag_vec
        assign tag_v_vec[gi] = tag_v_q[gi];
    end

    assign pipe_busy  = |tag_v_vec;
    assign pipe_empty = !pipe_busy && !(|cnt_nz);
    assign resp_p_d   = en ? mul_p : resp_p_q;

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     if (flush) state_d = DRAIN;
                DRAIN:   if (!flush && drained_q) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // drained follows an empty machine by one edge and drops on the edge leaving DRAIN.
    always_comb begin
        drained_d = drained_q;
        if (en) begin
            drained_d = (state_q == DRAIN) && (state_d == DRAIN) && pipe_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            resp_p_q     <= '0;
            resp_valid_q <= '0;
            drained_q    <= 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                cnt_q[k] <= '0;
            end
            for (int s = 0; s < DEPTH; s++) begin
                tag_v_q[s]  <= 1'b0;
                tag_id_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            resp_p_q     <= resp_p_d;
            resp_valid_q <= resp_valid_d;
            drained_q    <= drained_d;
            for (int k = 0; k < NREQ; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            for (int s = 0; s < DEPTH; s++) begin
                tag_v_q[s]  <= tag_v_d[s];
                tag_id_q[s] <= tag_id_d[s];
            end
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_en     = en;
    assign resp_p     = resp_p_q;
    assign resp_valid = resp_valid_q & {NREQ{en}};
    assign drained    = drained_q;

`ifdef BINARY_MUL_ARB_STATS_EN
    logic [15:0] gcnt_q [NREQ];
    logic [15:0] gcnt_d [NREQ];
    logic [31:0] busy_q, busy_d;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
        assign gcnt_d[gi] = (inc[gi] && (gcnt_q[gi] != 16'hFFFF)) ? gcnt_q[gi] + 16'd1 : gcnt_q[gi];
        assign grant_cnt[16*gi +: 16] = gcnt_q[gi];
    end

    assign busy_d   = (en && pipe_busy && (busy_q != 32'hFFFF_FFFF)) ? busy_q + 32'd1 : busy_q;
    assign busy_cnt = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int k = 0; k < NREQ; k++) begin
                gcnt_q[k] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int k = 0; k < NREQ; k++) begin
                gcnt_q[k] <= gcnt_d[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_binary_mul_13_arb.sv
// Directed bench for binary_mul_13_arb: reset, round-robin, credits, en stall, flush and mid-flight reset.
module tb_binary_mul_13_arb;

    localparam int NREQ = 4;
    localparam int LAT  = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              flush;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [13*NREQ-1:0] req_a;
    logic [13*NREQ-1:0] req_b;
    logic [NREQ-1:0]   resp_valid;
    logic [24:0]       resp_p;
    logic [12:0]       mul_a;
    logic [12:0]       mul_b;
    logic              mul_en;
    logic [24:0]       mul_p;
    logic              drained;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          acc_id[$];
    int          acc_edge[$];
    int          resp_id[$];
    int          resp_edge[$];
    logic [24:0] resp_val[$];
    int          exp_id[$];
    logic [24:0] exp_p[$];

    binary_mul_13_arb #(.NREQ(NREQ), .LATENCY(LAT), .MAX_OUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_p(resp_p),
        .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p),
        .drained(drained)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [24:0] prod(input logic signed [12:0] a, input logic signed [12:0] b);
        logic signed [25:0] t;
        t = a * b;
        return t[24:0];
    endfunction

    // Multiplier model: input capture stage plus LAT stages, frozen while mul_en is low.
    logic [24:0] mpipe [0:LAT];
    always @(posedge clk) begin
        if (mul_en) begin
            mpipe[0] <= prod(mul_a, mul_b);
            for (int s = 1; s <= LAT; s++) mpipe[s] <= mpipe[s-1];
        end
    end
    assign mul_p = mpipe[LAT];

    always @(negedge clk) begin
        if (rst_n && en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    acc_id.push_back(i);
                    acc_edge.push_back(cyc + 1);
                    $display("acc  edge=%0d req=%0d", cyc + 1, i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (resp_valid[i]) begin
                resp_id.push_back(i);
                resp_edge.push_back(cyc);
                resp_val.push_back(resp_p);
                $display("resp edge=%0d req=%0d p=0x%0h", cyc, i, resp_p);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [12:0] a, input logic [12:0] b);
        req_a[13*i +: 13] = a;
        req_b[13*i +: 13] = b;
    endtask

    task automatic clear_logs();
        acc_id.delete(); acc_edge.delete();
        resp_id.delete(); resp_edge.delete(); resp_val.delete();
        exp_id.delete(); exp_p.delete();
    endtask

    task automatic expect_op(input int id, input logic [24:0] p);
        exp_id.push_back(id);
        exp_p.push_back(p);
    endtask

    task automatic wait_resp(input int n, input int limit);
        for (int i = 0; i < limit && resp_id.size() < n; i++) step(1);
    endtask

    task automatic verify(input string name, input int lat);
        check({name, "_acc_count"}, acc_id.size(), exp_id.size());
        check({name, "_resp_count"}, resp_id.size(), exp_id.size());
        for (int i = 0; i < exp_id.size(); i++) begin
            if (i < acc_id.size() && i < resp_id.size()) begin
                check($sformatf("%s_acc_id%0d", name, i), acc_id[i], exp_id[i]);
                check($sformatf("%s_resp_id%0d", name, i), resp_id[i], exp_id[i]);
                check($sformatf("%s_resp_p%0d", name, i), resp_val[i], exp_p[i]);
                check($sformatf("%s_latency%0d", name, i), resp_edge[i] - acc_edge[i], lat);
            end
        end
    endtask

    logic [12:0] ra [8];
    logic [12:0] rb [8];
    int seen;

    initial begin
        ra = '{13'd100, -13'sd200, 13'd300, -13'sd400, 13'd4095, 13'h1000, 13'd7, 13'd0};
        rb = '{13'd3, 13'd5, -13'sd7, -13'sd9, 13'd4095, 13'd1, 13'h1000, 13'd123};

        rst_n = 1'b0; en = 1'b0; flush = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        step(2);
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_drained", drained, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_resp_p", resp_p, 0);
        check("rst_mul_en", mul_en, 0);

        rst_n = 1'b1;
        step(1);
        req_valid = 4'b0001;
        #1 check("idle_en0_ready", req_ready, 0);
        req_valid = '0;
        en = 1'b1;
        step(1);

        // Round-robin from requester 0, one grant per cycle.
        clear_logs();
        for (int i = 0; i < 4; i++) set_op(i, ra[i], rb[i]);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1 check($sformatf("rr_ready%0d", k), req_ready, 4'b0001 << (k % 4));
            expect_op(k % 4, prod(ra[k], rb[k]));
            step(1);
            if (k < 4) set_op(k, ra[k+4], rb[k+4]);
        end
        req_valid = '0;
        wait_resp(8, 40);
        verify("rr", 16);

        // Single op with the extreme negative operands.
        clear_logs();
        set_op(0, 13'h1000, 13'h1000);
        expect_op(0, 25'h100_0000);
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        check("single_mul_a", mul_a, 13'h1000);
        set_op(0, 13'h0AAA, 13'h0555);
        step(3);
        check("single_mul_a_hold", mul_a, 13'h1000);
        wait_resp(1, 40);
        verify("single", 16);

        // Credits: requester 1 alone stalls after four accepts until its first response.
        clear_logs();
        set_op(1, 13'd5, 13'd7);
        req_valid = 4'b0010;
        for (int c = 0; c <= 20; c++) begin
            #1;
            check($sformatf("cred_ready%0d", c), req_ready, (c < 4 || c >= 17) ? 4'b0010 : 4'b0000);
            check($sformatf("cred_resp%0d", c), resp_valid, (c >= 17) ? 4'b0010 : 4'b0000);
            step(1);
        end
        req_valid = '0;
        for (int i = 0; i < 8; i++) expect_op(1, 25'd35);
        wait_resp(8, 40);
        verify("cred", 16);

        // en stall for 5 cycles mid-flight.
        clear_logs();
        set_op(2, 13'h0FFF, 13'h1FFF);
        expect_op(2, 25'h1FF_F001);
        req_valid = 4'b0100;
        step(1);
        req_valid = '0;
        step(4);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("stall_resp%0d", i), resp_valid, 0);
            check($sformatf("stall_mul_en%0d", i), mul_en, 0);
        end
        check("stall_mul_a", mul_a, 13'h0FFF);
        en = 1'b1;
        wait_resp(1, 40);
        verify("stall", 21);

        // Flush with three in flight.
        clear_logs();
        set_op(0, -13'sd3, 13'd11);     expect_op(0, 25'h1FF_FFDF);
        req_valid = 4'b0001;
        step(1);
        set_op(0, 13'd12, 13'd12);      expect_op(0, 25'd144);
        step(1);
        set_op(0, -13'sd100, -13'sd100); expect_op(0, 25'd10000);
        step(1);
        flush = 1'b1;
        #1 check("flush_ready", req_ready, 0);
        step(1);
        seen = 0;
        for (int i = 0; i < 40 && seen < 3; i++) begin
            step(1);
            if (resp_valid[0]) seen++;
        end
        check("flush_resp_seen", seen, 3);
        check("flush_drained_early", drained, 0);
        check("flush_no_accept", acc_id.size(), 3);
        step(1);
        check("flush_drained", drained, 1);
        flush = 1'b0;
        step(1);
        #1 check("flush_resume_ready", req_ready, 4'b0001);
        check("flush_drained_clear", drained, 0);
        req_valid = '0;
        step(20);
        verify("flush", 16);

        // Reset with five in flight.
        for (int i = 0; i < 4; i++) set_op(i, 13'd9 + 13'(i), 13'd2);
        req_valid = 4'hF;
        step(5);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        clear_logs();
        check("mrst_resp_valid", resp_valid, 0);
        check("mrst_ready_idle", req_ready, 0);
        step(1);
        #1 check("mrst_priority0", req_ready, 4'b0001);
        req_valid = '0;
        step(30);
        check("mrst_no_resp", resp_id.size(), 0);
        check("mrst_no_accept", acc_id.size(), 0);
        flush = 1'b1;
        step(2);
        check("mrst_drained", drained, 1);
        flush = 1'b0;
        step(1);
        check("mrst_drained_clear", drained, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
